// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: loads opcodes into the instruction memory while idle, then
// walks it, capturing and splitting each 27-bit word for the execution engine.
module instr_fetch #(
  parameter int unsigned PROG_LEN  = 5,
  parameter int unsigned MAX_WORDS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        load_valid,
  input  logic [26:0] load_data,
  output logic        load_ready,
  output logic [3:0]  load_count,
  output logic [3:0]  mem_pointer,
  output logic        mem_write_data,
  output logic        mem_read_data,
  output logic [26:0] mem_data_to_write,
  input  logic [26:0] mem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [4:0]  instr_opcode,
  output logic [6:0]  instr_dest,
  output logic [6:0]  instr_src1,
  output logic [6:0]  instr_src2,
  output logic [7:0]  instr_scalar,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] MaxWords = 4'(MAX_WORDS);
  localparam logic [3:0] ProgLen  = 4'(PROG_LEN);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StIssue
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [3:0]  run_len_q, run_len_d;
  logic [3:0]  load_count_q, load_count_d;
  logic [26:0] instr_q, instr_d;
  logic        done_q, done_d;
  logic        wr_en;

  // start wins over a simultaneous load offer
  assign load_ready = (state_q == StIdle) && (load_count_q < MaxWords);
  assign wr_en      = load_valid & load_ready & ~start;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    run_len_d    = run_len_q;
    load_count_d = load_count_q;
    instr_d      = instr_q;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_d      = 4'd0;
          run_len_d = (load_count_q != 4'd0) ? load_count_q : ProgLen;
          state_d   = StReq;
        end else if (wr_en) begin
          load_count_d = load_count_q + 4'd1;
        end
      end
      StReq: begin
        state_d = StWait;
      end
      StWait: begin
        instr_d = mem_data;
        state_d = StIssue;
      end
      StIssue: begin
        if (instr_ready) begin
          if (pc_q == run_len_q - 4'd1) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            pc_d    = pc_q + 4'd1;
            state_d = StReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= 4'd0;
      run_len_q    <= 4'd0;
      load_count_q <= 4'd0;
      instr_q      <= 27'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      run_len_q    <= run_len_d;
      load_count_q <= load_count_d;
      instr_q      <= instr_d;
      done_q       <= done_d;
    end
  end

  assign load_count        = load_count_q;
  assign mem_pointer       = (state_q == StIdle) ? load_count_q : pc_q;
  assign mem_write_data    = wr_en;
  assign mem_read_data     = (state_q == StReq);
  assign mem_data_to_write = load_data;
  assign instr_valid       = (state_q == StIssue);
  assign busy              = (state_q != StIdle);
  assign done              = done_q;

  // scalar deliberately overlaps src2
  assign instr_opcode = instr_q[26:22];
  assign instr_dest   = instr_q[21:15];
  assign instr_src1   = instr_q[14:8];
  assign instr_src2   = instr_q[7:1];
  assign instr_scalar = instr_q[7:0];

  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (instr_valid && !instr_ready) |=> (instr_valid && $stable(instr_q)));
  a_no_rw_clash: assert property (@(posedge clk) disable iff (reset)
    !(mem_read_data && mem_write_data));
  a_pc_bound: assert property (@(posedge clk) disable iff (reset)
    busy |-> (pc_q < run_len_q));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural instruction memory and transfer log.
module tb_instr_fetch;

  typedef struct packed {
    logic [4:0] op;
    logic [6:0] d;
    logic [6:0] s1;
    logic [6:0] s2;
    logic [7:0] sc;
  } fields_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        load_valid = 1'b0;
  logic [26:0] load_data = '0;
  logic        load_ready;
  logic [3:0]  load_count;
  logic [3:0]  mem_pointer;
  logic        mem_write_data;
  logic        mem_read_data;
  logic [26:0] mem_data_to_write;
  logic [26:0] mem_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [4:0]  instr_opcode;
  logic [6:0]  instr_dest;
  logic [6:0]  instr_src1;
  logic [6:0]  instr_src2;
  logic [7:0]  instr_scalar;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;
  logic [26:0] tb_mem [16];
  logic [3:0]  wr_log [$];
  fields_t     xfer_q [$];

  instr_fetch #(.PROG_LEN(5), .MAX_WORDS(10)) dut (
    .clk(clk), .reset(reset), .start(start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_count(load_count), .mem_pointer(mem_pointer),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_data_to_write(mem_data_to_write), .mem_data(mem_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_opcode(instr_opcode), .instr_dest(instr_dest),
    .instr_src1(instr_src1), .instr_src2(instr_src2), .instr_scalar(instr_scalar),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] preset(input int i);
    return 27'h0010002 + (27'(i) << 22);
  endfunction

  function automatic fields_t split(input logic [26:0] w);
    return '{op: w[26:22], d: w[21:15], s1: w[14:8], s2: w[7:1], sc: w[7:0]};
  endfunction

  function automatic fields_t live();
    return '{op: instr_opcode, d: instr_dest, s1: instr_src1, s2: instr_src2, sc: instr_scalar};
  endfunction

  // memory model plus event monitors
  always @(posedge clk) begin
    if (mem_write_data) begin
      tb_mem[mem_pointer] <= mem_data_to_write;
      wr_log.push_back(mem_pointer);
    end
    if (mem_read_data) begin
      mem_data <= tb_mem[mem_pointer];
      rd_cnt   <= rd_cnt + 1;
    end
    if (instr_valid && instr_ready) xfer_q.push_back(live());
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done) break;
    end
    check_eq("done_seen", done, 1);
    check_eq("busy_at_done", busy, 0);
    tick();
    check_eq("done_one_cycle", done, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_valid"}, instr_valid, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_rd"}, mem_read_data, 0);
    check_eq({tag, "_wr"}, mem_write_data, 0);
    check_eq({tag, "_ldrdy"}, load_ready, 1);
    check_eq({tag, "_ldcnt"}, load_count, 0);
    check_eq({tag, "_ptr"}, mem_pointer, 0);
    check_eq({tag, "_fields"}, live(), 0);
  endtask

  initial begin
    logic [26:0] words [3];
    int rd0;
    int d0;
    words[0] = 27'h7FFFFFF;
    words[1] = 27'h0000001;
    words[2] = 27'h4010200;
    for (int i = 0; i < 16; i++) tb_mem[i] = preset(i);

    // reset values
    #12;
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // default program, with start -> valid latency
    pulse_start();
    check_eq("req_busy", busy, 1);
    check_eq("req_strobe", mem_read_data, 1);
    check_eq("req_ptr", mem_pointer, 0);
    tick();
    check_eq("wait_strobe", mem_read_data, 0);
    check_eq("wait_valid", instr_valid, 0);
    tick();
    check_eq("issue_valid", instr_valid, 1);
    check_eq("w0_op", instr_opcode, 0);
    check_eq("w0_dest", instr_dest, 2);
    check_eq("w0_src1", instr_src1, 0);
    check_eq("w0_src2", instr_src2, 1);
    check_eq("w0_scalar", instr_scalar, 2);
    instr_ready = 1'b1;
    wait_done();
    check_eq("dflt_xfers", xfer_q.size(), 5);
    for (int i = 0; i < 5 && i < xfer_q.size(); i++)
      check_eq($sformatf("dflt_w%0d", i), xfer_q[i], split(preset(i)));
    check_eq("dflt_done_cnt", done_cnt, 1);

    // load three words then run them
    instr_ready = 1'b0;
    wr_log.delete();
    xfer_q.delete();
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = words[i];
      #1;
      check_eq($sformatf("ld_wr%0d", i), mem_write_data, 1);
      check_eq($sformatf("ld_ptr%0d", i), mem_pointer, i);
      tick();
    end
    load_valid = 1'b0;
    check_eq("ld_count", load_count, 3);
    check_eq("ld_strobes", wr_log.size(), 3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++)
      check_eq($sformatf("ld_addr%0d", i), wr_log[i], i);
    pulse_start();
    instr_ready = 1'b1;
    wait_done();
    check_eq("ld_xfers", xfer_q.size(), 3);
    for (int i = 0; i < 3 && i < xfer_q.size(); i++)
      check_eq($sformatf("ld_w%0d", i), xfer_q[i], split(words[i]));
    if (xfer_q.size() == 3) begin
      check_eq("w2_op", xfer_q[2].op, 16);
      check_eq("w2_dest", xfer_q[2].d, 2);
      check_eq("w2_src1", xfer_q[2].s1, 2);
      check_eq("w2_src2", xfer_q[2].s2, 0);
    end

    // back-pressure in ISSUE
    instr_ready = 1'b0;
    xfer_q.delete();
    pulse_start();
    for (int i = 0; i < 10 && !instr_valid; i++) tick();
    check_eq("bp_valid", instr_valid, 1);
    rd0 = rd_cnt;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq($sformatf("bp_hold%0d", i), instr_valid, 1);
      check_eq($sformatf("bp_fields%0d", i), live(), split(27'h7FFFFFF));
      check_eq($sformatf("bp_pc%0d", i), mem_pointer, 0);
    end
    check_eq("bp_no_read", rd_cnt, rd0);
    instr_ready = 1'b1;
    tick();
    check_eq("bp_next_read", mem_read_data, 1);
    check_eq("bp_next_ptr", mem_pointer, 1);
    wait_done();
    check_eq("bp_xfers", xfer_q.size(), 3);

    // start/load conflict and start while busy
    reset = 1'b1;
    tick();
    reset = 1'b0;
    instr_ready = 1'b0;
    wr_log.delete();
    xfer_q.delete();
    start = 1'b1;
    load_valid = 1'b1;
    load_data = 27'h5555;
    #1;
    check_eq("cf_no_write", mem_write_data, 0);
    tick();
    check_eq("cf_busy", busy, 1);
    check_eq("cf_count", load_count, 0);
    #1;
    check_eq("busy_no_write", mem_write_data, 0);
    check_eq("busy_ldrdy", load_ready, 0);
    tick();
    start = 1'b0;
    load_valid = 1'b0;
    check_eq("busy_count", load_count, 0);
    check_eq("busy_strobes", wr_log.size(), 0);
    instr_ready = 1'b1;
    wait_done();
    check_eq("cf_xfers", xfer_q.size(), 5);
    for (int i = 0; i < 5 && i < xfer_q.size(); i++)
      check_eq($sformatf("cf_w%0d", i), xfer_q[i], split(i < 3 ? words[i] : preset(i)));

    // fill: 12 offered, 10 written
    instr_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      load_valid = 1'b1;
      load_data  = 27'h100 + 27'(i);
      tick();
    end
    check_eq("fill_strobes", wr_log.size(), 10);
    check_eq("fill_count", load_count, 10);
    check_eq("fill_ldrdy", load_ready, 0);
    check_eq("fill_no_write", mem_write_data, 0);
    if (wr_log.size() == 10) check_eq("fill_last_addr", wr_log[9], 9);
    load_valid = 1'b0;
    xfer_q.delete();
    pulse_start();
    instr_ready = 1'b1;
    wait_done();
    check_eq("fill_xfers", xfer_q.size(), 10);
    for (int i = 0; i < 10 && i < xfer_q.size(); i++)
      check_eq($sformatf("fill_w%0d", i), xfer_q[i], split(27'h100 + 27'(i)));

    // reset in WAIT of the third instruction
    xfer_q.delete();
    pulse_start();
    for (int i = 0; i < 40; i++) begin
      if (xfer_q.size() == 2 && busy && !mem_read_data && !instr_valid) break;
      tick();
    end
    check_eq("mr_in_wait", {busy, mem_read_data, instr_valid}, 3'b100);
    d0 = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("mr");
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_eq("mr_no_done", done_cnt, d0);
    check_eq("mr_xfers", xfer_q.size(), 2);
    xfer_q.delete();
    pulse_start();
    wait_done();
    check_eq("mr2_xfers", xfer_q.size(), 5);
    for (int i = 0; i < 5 && i < xfer_q.size(); i++)
      check_eq($sformatf("mr2_w%0d", i), xfer_q[i], split(27'h100 + 27'(i)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch sequencer that drives the instruction memory as its initiator: it steps the memory pointer, strobes reads, captures each 27-bit opcode, and splits it into fields. It hands each instruction to the execution engine over a valid/ready handshake. While idle, it also serves as the program loader, writing incoming opcodes into the memory through the same port. It sits between the instruction memory and the exe_engine.

## Interface

Parameters:
- PROG_LEN, 5: run length used when no words have been loaded since reset.
- MAX_WORDS, 10: memory depth. Loads stop at this count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  begins a fetch run at address 0; sampled only in IDLE.
- load_valid  in  1  a word on load_data is offered for writing.
- load_data  in  27  opcode to store.
- load_ready  out  1  high in IDLE when load_count < MAX_WORDS.
- load_count  out  4  number of words written since reset.
- mem_pointer  out  4  memory address: load_count in IDLE, pc otherwise.
- mem_write_data  out  1  equals load_valid & load_ready & ~start.
- mem_read_data  out  1  high only in state REQ.
- mem_data_to_write  out  27  equals load_data.
- mem_data  in  27  memory read data; valid from the edge after a read strobe is sampled.
- instr_valid  out  1  a decoded instruction is presented.
- instr_ready  in  1  the execution engine accepts the presented instruction.
- instr_opcode  out  5  bits [26:22].
- instr_dest  out  7  bits [21:15].
- instr_src1  out  7  bits [14:8].
- instr_src2  out  7  bits [7:1].
- instr_scalar  out  8  bits [7:0]; overlaps src2 by design.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on completion of a run.

## Operation

- States: IDLE, REQ, WAIT, ISSUE.
- Run length is latched at start: run_len = load_count if load_count ≠ 0, else PROG_LEN.
- IDLE:
  - Each cycle with mem_write_data high writes load_data to address load_count, and load_count increments.
  - start has priority over a simultaneous load. With both high, no write occurs, pc clears to 0, run_len is latched, and the next state is REQ.
- REQ:
  - mem_read_data is high and mem_pointer = pc.
  - Next state is WAIT unconditionally.
- WAIT:
  - mem_data is valid in this state.
  - At the end of the cycle, mem_data is captured into the instruction register and the next state is ISSUE.
- ISSUE:
  - instr_valid is high, and all fields are stable until acceptance.
  - Handshake: transfer occurs on an edge where instr_valid & instr_ready are both high. Field outputs do not change while instr_valid is high and not yet accepted.
  - On transfer with pc == run_len−1: pulse done, go to IDLE.
  - On transfer otherwise: pc increments, go to REQ.
- start, load_valid and load_data are ignored while busy.
- pc is 4-bit and never exceeds run_len−1 (at most 9), so it never wraps.
- Reset does not clear the memory contents.
- Reset during a run:
  - Forces IDLE immediately, with no done pulse.
  - Any outstanding instruction is dropped.
  - The memory read strobe deasserts asynchronously.

## Timing

Reset values:
- Internal state: IDLE; pc = 0, load_count = 0.
- Control outputs: instr_valid = 0, busy = 0, done = 0, mem_read_data = 0, mem_write_data = 0.
- All instruction fields are 0.
- load_ready = 1 after reset, since load_count = 0 < MAX_WORDS.

Latencies:
- start sampled at edge E gives REQ in cycle E+1, WAIT in E+2, and instr_valid high in E+3.
- Minimum throughput is 3 cycles per instruction, with instr_ready held high.
- done is asserted in the cycle after the final transfer; busy falls in that same cycle.
- Loads are single-cycle: one write per cycle while load_valid & load_ready.

## Test plan

- Reset values: assert reset mid-cycle → every output is at its reset value before the next edge; load_ready = 1.
- Default program: with no loads, pulse start. The memory holds its preset program; word 0 is 000000000010000000000000010.
  - First issue: opcode 0, dest 2, src1 0, src2 1, scalar 2, valid at start+3.
  - Five transfers occur, then done pulses once.
- Load then run: write 0x7FFFFFF, 0x0000001, 0x4010200 → load_count = 3, with three write strobes at pointers 0, 1, 2.
  - Then start → three instructions issue in that order.
  - Word 0x4010200 decodes to opcode 16, dest 2, src1 2, src2 0.
- Back-pressure: hold instr_ready low for 7 cycles in ISSUE → fields are unchanged, no new read strobe occurs, and pc is unchanged.
  - Release → the next mem_read_data is asserted on the following cycle.
- Full and conflicts: offer 12 load words → only 10 are written and load_ready drops at count 10.
  - start together with load_valid → no write.
  - start while busy → ignored.
- Reset mid-run: assert reset in WAIT of instruction 2 → IDLE, busy = 0, no done.
  - A fresh start issues from address 0 again.
